// File: rtl/agc_step24_pkg.sv
// Shared definitions for the AGC step generator: state encodings,
// step width and the decay-step negation helper.
package agc_step24_pkg;

   localparam int STEP_W = 24;

   typedef enum logic [1:0] {
      ST_DECAY  = 2'd0,
      ST_ATTACK = 2'd1,
      ST_HANG   = 2'd2
   } agc_st_e;

   // Two's-complement negative of a zero-extended 16-bit decay magnitude.
   // A zero magnitude yields a zero step.
   function automatic logic [STEP_W-1:0] neg_step(input logic [15:0] m);
      return ~{8'h00, m} + 24'd1;
   endfunction

endpackage

// File: rtl/agc_step24_scale.sv
// Attack-step scaler: zero-extends the excess over threshold to the step
// width and shifts it left by the attack gain. With MW+7 <= 23 the result
// always stays positive as a signed 24-bit step.
module agc_step_scale
   import agc_step24_pkg::*;
#(
   parameter int MW = 16
) (
   input  logic [MW-1:0]     ex,
   input  logic [2:0]        sh,
   output logic [STEP_W-1:0] step
);

   // Barrel shift of the widened excess.
   always_comb begin
      step = {{(STEP_W-MW){1'b0}}, ex} << sh;
   end

endmodule

// File: rtl/agc_step24.sv
// AGC error/step generator. Two-stage pipeline: stage 1 compares the
// envelope magnitude with the threshold, stage 2 runs the attack/hang/decay
// state machine and registers the signed step together with its enable.
// The downstream accumulator does all saturation; no clamping here.
module agc_step24
   import agc_step24_pkg::*;
#(
   parameter int MW = 16,
   parameter int HW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MW-1:0]     mag,
   input  logic              mag_v,
   input  logic [MW-1:0]     thresh,
   input  logic [2:0]        atk_sh,
   input  logic [15:0]       dcy,
   input  logic [HW-1:0]     hang,
   input  logic              freeze,
   output logic [STEP_W-1:0] d,
   output logic              ce,
   output logic [1:0]        st
);

   // Stage-1 pipeline registers
   logic              s1_v_q, s1_v_d;
   logic              ovr_q, ovr_d;
   logic [MW-1:0]     ex_q, ex_d;

   // Stage-2 state and output registers
   agc_st_e           state_q, state_d;
   logic [HW-1:0]     cnt_q, cnt_d;
   logic [STEP_W-1:0] d_q, d_d;
   logic              ce_q, ce_d;

   logic [STEP_W-1:0] scaled_s;
   logic [STEP_W-1:0] decay_s;

   agc_step_scale #(.MW(MW)) u_scale (
      .ex   (ex_q),
      .sh   (atk_sh),
      .step (scaled_s)
   );

   assign decay_s = neg_step(dcy);

   // Stage 1: capture the over-threshold flag and excess for each sample.
   always_comb begin
      s1_v_d = mag_v;
      ovr_d  = ovr_q;
      ex_d   = ex_q;
      if (mag_v) begin
         ovr_d = (mag > thresh);
         if (mag > thresh) begin
            ex_d = mag - thresh;
         end else begin
            ex_d = {MW{1'b0}};
         end
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Stage 2: attack/hang/decay transitions and step selection per sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_d     = {STEP_W{1'b0}};
      ce_d    = 1'b0;
      if (s1_v_q) begin
         ce_d = 1'b1;
         if (freeze) begin
            // Sample consumed with a zero step; state and counter hold.
            d_d = {STEP_W{1'b0}};
         end else if (ovr_q) begin
            state_d = ST_ATTACK;
            cnt_d   = hang;
            d_d     = scaled_s;
         end else begin
            case (state_q)
               ST_ATTACK: begin
                  if (hang != {HW{1'b0}}) begin
                     state_d = ST_HANG;
                     cnt_d   = hang - {{(HW-1){1'b0}}, 1'b1};
                  end else begin
                     state_d = ST_DECAY;
                     d_d     = decay_s;
                  end
               end
               ST_HANG: begin
                  if (cnt_q != {HW{1'b0}}) begin
                     cnt_d = cnt_q - {{(HW-1){1'b0}}, 1'b1};
                  end else begin
                     state_d = ST_DECAY;
                     d_d     = decay_s;
                  end
               end
               ST_DECAY: begin
                  d_d = decay_s;
               end
               default: begin
                  // Unused encoding recovers to decay.
                  state_d = ST_DECAY;
                  d_d     = decay_s;
               end
            endcase
         end
      end else begin
         ce_d = 1'b0;
      end
   end

   // All pipeline and state registers; reset drops any in-flight sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v_q  <= 1'b0;
         ovr_q   <= 1'b0;
         ex_q    <= {MW{1'b0}};
         state_q <= ST_DECAY;
         cnt_q   <= {HW{1'b0}};
         d_q     <= {STEP_W{1'b0}};
         ce_q    <= 1'b0;
      end else begin
         s1_v_q  <= s1_v_d;
         ovr_q   <= ovr_d;
         ex_q    <= ex_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         ce_q    <= ce_d;
      end
   end

   assign d  = d_q;
   assign ce = ce_q;
   assign st = state_q;

endmodule

// File: tb/tb_agc_step24.sv
// Self-checking bench for agc_step24: a sample-level behavioural model
// checked every cycle, plus directed samples with literal expected steps.
module tb_agc_step24;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] mag = 16'd0;
   logic        mag_v = 1'b0;
   logic [15:0] thresh = 16'd0;
   logic [2:0]  atk_sh = 3'd0;
   logic [15:0] dcy = 16'd0;
   logic [15:0] hang = 16'd0;
   logic        freeze = 1'b0;
   logic [23:0] d;
   logic        ce;
   logic [1:0]  st;

   int total = 0;
   int passed = 0;

   agc_step24 #(.MW(16), .HW(16)) dut (
      .clk(clk), .rst(rst), .mag(mag), .mag_v(mag_v), .thresh(thresh),
      .atk_sh(atk_sh), .dcy(dcy), .hang(hang), .freeze(freeze),
      .d(d), .ce(ce), .st(st)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // Behavioural model: one pending sample, a mode (0 decay, 1 attack,
   // 2 hang) and the remaining hang samples.
   int m_v1, m_ovr, m_ex, m_mode, m_cnt, m_ce, m_d;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_v1 = 0; m_ovr = 0; m_ex = 0; m_mode = 0; m_cnt = 0; m_ce = 0; m_d = 0;
      end else begin
         m_ce = 0;
         m_d  = 0;
         if (m_v1 != 0) begin
            m_ce = 1;
            if (freeze) begin
               m_d = 0;
            end else if (m_ovr != 0) begin
               m_mode = 1;
               m_cnt  = int'(hang);
               m_d    = m_ex * (1 << atk_sh);
            end else if (m_mode == 1 && hang != 16'd0) begin
               m_mode = 2;
               m_cnt  = int'(hang) - 1;
            end else if (m_mode == 2 && m_cnt > 0) begin
               m_cnt = m_cnt - 1;
            end else begin
               m_mode = 0;
               m_d    = (16777216 - int'(dcy)) % 16777216;
            end
         end
         m_v1 = mag_v ? 1 : 0;
         if (mag_v) begin
            m_ovr = (mag > thresh) ? 1 : 0;
            m_ex  = (mag > thresh) ? (int'(mag) - int'(thresh)) : 0;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("cyc ce", 32'(ce), 32'(m_ce));
      chk("cyc st", 32'(st), 32'(m_mode));
      if (m_ce != 0) chk("cyc d", 32'(d), 32'(m_d));
   end

   // One sample; checks no ce after 1 clk and the literal step after 2 clk.
   task automatic sample(input logic [15:0] m, input logic [23:0] ed,
                         input logic [1:0] es, input string nm);
      @(negedge clk);
      mag   = m;
      mag_v = 1'b1;
      @(negedge clk);
      mag_v = 1'b0;
      chk({nm, " lat1 ce"}, 32'(ce), 32'd0);
      @(negedge clk);
      chk({nm, " ce"}, 32'(ce), 32'd1);
      chk({nm, " d"}, 32'(d), 32'(ed));
      chk({nm, " st"}, 32'(st), 32'(es));
      chk({nm, " model d"}, 32'(m_d), 32'(ed));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      int nce;
      // Reset held with mag_v toggling
      mag = 16'h1400;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mag_v = ~mag_v;
         #1;
         chk("rst d", 32'(d), 32'd0);
         chk("rst ce", 32'(ce), 32'd0);
         chk("rst st", 32'(st), 32'd0);
      end
      @(negedge clk);
      mag_v = 1'b0;
      rst = 1'b1;

      // Attack then hang then decay
      thresh = 16'h1000; atk_sh = 3'd3; hang = 16'd3; dcy = 16'h0010;
      sample(16'h1400, 24'h002000, 2'd1, "attack");
      sample(16'h0800, 24'h000000, 2'd2, "hang1");
      sample(16'h0800, 24'h000000, 2'd2, "hang2");
      sample(16'h0800, 24'h000000, 2'd2, "hang3");
      sample(16'h0800, 24'hFFFFF0, 2'd0, "decay1");
      sample(16'h0800, 24'hFFFFF0, 2'd0, "decay2");

      // Boundaries
      sample(16'h1000, 24'hFFFFF0, 2'd0, "mag_eq_thr");
      hang = 16'd0;
      sample(16'h1400, 24'h002000, 2'd1, "atk_h0");
      sample(16'h0800, 24'hFFFFF0, 2'd0, "h0_decay");
      thresh = 16'h0000; atk_sh = 3'd7;
      sample(16'hFFFF, 24'h7FFF80, 2'd1, "max_step");
      thresh = 16'h1000; atk_sh = 3'd3; dcy = 16'h0000;
      sample(16'h0800, 24'h000000, 2'd0, "dcy_zero");

      // Freeze during hang with counter at 2
      hang = 16'd3; dcy = 16'h0010;
      sample(16'h1400, 24'h002000, 2'd1, "fz_attack");
      sample(16'h0800, 24'h000000, 2'd2, "fz_hang");
      freeze = 1'b1;
      sample(16'h0800, 24'h000000, 2'd2, "frz1");
      sample(16'h0800, 24'h000000, 2'd2, "frz2");
      sample(16'h0800, 24'h000000, 2'd2, "frz3");
      freeze = 1'b0;
      sample(16'h0800, 24'h000000, 2'd2, "post_frz1");
      sample(16'h0800, 24'h000000, 2'd2, "post_frz2");
      sample(16'h0800, 24'hFFFFF0, 2'd0, "post_frz_dcy");

      // Back-to-back burst of 8 alternating samples
      hang = 16'd0;
      nce = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ce) nce++;
         mag_v = 1'b1;
         mag = (i % 2 == 1) ? 16'h0800 : 16'h1400;
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ce) nce++;
         mag_v = 1'b0;
      end
      chk("burst ce count", 32'(nce), 32'd8);

      // Reset in the middle of a burst
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mag_v = 1'b1;
         mag = (i % 2 == 1) ? 16'h0800 : 16'h1400;
      end
      #2;
      rst = 1'b0;
      #1;
      chk("midrst ce", 32'(ce), 32'd0);
      chk("midrst d", 32'(d), 32'd0);
      chk("midrst st", 32'(st), 32'd0);
      @(negedge clk);
      @(negedge clk);
      mag_v = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst ce", 32'(ce), 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
